// File: rtl/bloco_pkg.sv
// Shared types for the pipelined register-bank + ALU datapath.
package bloco_pkg;

  typedef enum logic [4:0] {
    OP_PASS_A = 5'h00,
    OP_ADD    = 5'h01,
    OP_SUB    = 5'h02,
    OP_AND    = 5'h03,
    OP_OR     = 5'h04,
    OP_XOR    = 5'h05,
    OP_NOT_A  = 5'h06,
    OP_INC_A  = 5'h07,
    OP_DEC_A  = 5'h08,
    OP_SHL_A  = 5'h09,
    OP_SHR_A  = 5'h0A,
    OP_ASR_A  = 5'h0B,
    OP_MUL    = 5'h0C
  } op_t;

  // flag bit positions inside {Z,N,C,V}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // issue FSM encoding
  typedef logic [0:0] state_t;
  localparam state_t ST_RUN = 1'b0;
  localparam state_t ST_MUL = 1'b1;

endpackage

// File: rtl/bloco_banco_registros.sv
// Register bank: two combinational read ports, one synchronous write port.
module bloco_banco_registros #(
  parameter int W  = 16,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_a,
  output logic [W-1:0]  rdata_b
);
  localparam int NREG = 2 ** AW;

  logic [NREG-1:0][W-1:0] regs;

  // single write port, whole bank cleared on reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  regs <= '0;
    else if (we)   regs[waddr] <= wdata;
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/bloco_datapath_pipe.sv
// Register bank + ALU datapath with valid/ready issue, EX->WB pipeline,
// WB->EX forwarding and an iterative shift-add multiplier.
module bloco_datapath_pipe
  import bloco_pkg::*;
#(
  parameter int BITS_PALAVRA  = 16,
  parameter int END_REGISTROS = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [END_REGISTROS-1:0] Sel_SA,
  input  logic [END_REGISTROS-1:0] Sel_SB,
  input  logic [END_REGISTROS-1:0] Sel_SC,
  input  logic [4:0]               controleOperacao,
  input  logic                     Hab_Escrita,
  input  logic                     Hab_Flags,
  input  logic                     clear_Flags,
  output logic                     out_valid,
  output logic [BITS_PALAVRA-1:0]  out_result,
  output logic [3:0]               out_flags,
  output logic                     busy
);
  localparam int W  = BITS_PALAVRA;
  localparam int AW = END_REGISTROS;
  localparam int CW = $clog2(W);

  typedef struct packed {
    logic          valid;
    logic          write;
    logic          flag_en;
    logic [AW-1:0] dst;
    logic [W-1:0]  result;
    logic [3:0]    flags;
  } wb_t;

  // single-cycle ALU; returns {Z,N,C,V,result}
  function automatic logic [W+3:0] alu(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         c, v;
    s = '0; r = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_PASS_A: r = a;
      OP_ADD:   begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W];
                      v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
      OP_SUB:   begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W];
                      v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_NOT_A:  r = ~a;
      OP_INC_A: begin s = {1'b0, a} + (W+1)'(1); r = s[W-1:0]; c = s[W];
                      v = ~a[W-1] & r[W-1]; end
      OP_DEC_A: begin s = {1'b0, a} - (W+1)'(1); r = s[W-1:0]; c = s[W];
                      v = a[W-1] & ~r[W-1]; end
      OP_SHL_A: begin r = {a[W-2:0], 1'b0};   c = a[W-1]; end
      OP_SHR_A: begin r = {1'b0, a[W-1:1]};   c = a[0];   end
      OP_ASR_A: begin r = {a[W-1], a[W-1:1]}; c = a[0];   end
      default:   r = '0;
    endcase
    return {(r == '0), r[W-1], c, v, r};
  endfunction

  state_t        state;
  wb_t           wb;
  logic [3:0]    flags;
  logic [W-1:0]  rdata_a, rdata_b, opa, opb;
  logic [W+3:0]  alu_out;
  logic          accept, is_mul, valid_op;

  logic [2*W-1:0] mul_acc, mul_mcand, acc_next;
  logic [W-1:0]   mul_mplier;
  logic [CW-1:0]  mul_cnt;
  logic           mul_last;
  logic           pend_write, pend_flag;
  logic [AW-1:0]  pend_dst;

  assign in_ready = (state == ST_RUN);
  assign busy     = (state == ST_MUL);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (controleOperacao == 5'(OP_MUL));
  assign valid_op = (controleOperacao <= 5'(OP_MUL));

  bloco_banco_registros #(.W(W), .AW(AW)) u_banco (
    .clk     (clk),
    .reset_n (reset_n),
    .we      (wb.valid && wb.write),
    .waddr   (wb.dst),
    .wdata   (wb.result),
    .raddr_a (Sel_SA),
    .raddr_b (Sel_SB),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  // the WB entry is not in the bank yet, so it overrides a matching read
  assign opa     = (wb.valid && wb.write && wb.dst == Sel_SA) ? wb.result : rdata_a;
  assign opb     = (wb.valid && wb.write && wb.dst == Sel_SB) ? wb.result : rdata_b;
  assign alu_out = alu(op_t'(controleOperacao), opa, opb);

  assign acc_next = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last = (mul_cnt == CW'(W - 1));

  // issue FSM and multiplier iterator; dst/enables ride along with the MUL
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      pend_write <= 1'b0;
      pend_flag  <= 1'b0;
      pend_dst   <= '0;
    end else if (state == ST_RUN) begin
      if (accept && is_mul) begin
        state      <= ST_MUL;
        mul_acc    <= '0;
        mul_mcand  <= {{W{1'b0}}, opa};
        mul_mplier <= opb;
        mul_cnt    <= '0;
        pend_write <= Hab_Escrita;
        pend_flag  <= Hab_Flags;
        pend_dst   <= Sel_SC;
      end
    end else begin
      mul_acc    <= acc_next;
      mul_mcand  <= mul_mcand << 1;
      mul_mplier <= mul_mplier >> 1;
      mul_cnt    <= mul_cnt + CW'(1);
      if (mul_last) state <= ST_RUN;
    end
  end

  // WB stage: loaded by a non-MUL accept or by the last MUL iteration
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wb <= '0;
    end else if (state == ST_MUL && mul_last) begin
      wb.valid         <= 1'b1;
      wb.write         <= pend_write;
      wb.flag_en       <= pend_flag;
      wb.dst           <= pend_dst;
      wb.result        <= acc_next[W-1:0];
      wb.flags[FLAG_Z] <= (acc_next[W-1:0] == '0);
      wb.flags[FLAG_N] <= acc_next[W-1];
      wb.flags[FLAG_C] <= |acc_next[2*W-1:W];
      wb.flags[FLAG_V] <= 1'b0;
    end else if (accept && !is_mul) begin
      wb.valid   <= 1'b1;
      wb.write   <= Hab_Escrita && valid_op;
      wb.flag_en <= Hab_Flags && valid_op;
      wb.dst     <= Sel_SC;
      wb.result  <= alu_out[W-1:0];
      wb.flags   <= alu_out[W+3:W];
    end else begin
      wb <= '0;
    end
  end

  // architectural flags; a clear beats a retiring update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                    flags <= '0;
    else if (clear_Flags)            flags <= '0;
    else if (wb.valid && wb.flag_en) flags <= wb.flags;
  end

  assign out_valid  = wb.valid;
  assign out_result = wb.valid ? wb.result : '0;
  assign out_flags  = flags;

endmodule

// File: tb/tb_bloco_datapath_pipe.sv
// Directed + randomized bench for bloco_datapath_pipe against an
// architectural (one-op-at-a-time) reference model.
module tb_bloco_datapath_pipe;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] Sel_SA = '0, Sel_SB = '0, Sel_SC = '0;
  logic [4:0] controleOperacao = '0;
  logic       Hab_Escrita = 1'b0, Hab_Flags = 1'b0, clear_Flags = 1'b0;
  logic       out_valid;
  logic [15:0] out_result;
  logic [3:0] out_flags;
  logic       busy;

  always #5 clk = ~clk;

  bloco_datapath_pipe #(.BITS_PALAVRA(16), .END_REGISTROS(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Sel_SA(Sel_SA), .Sel_SB(Sel_SB), .Sel_SC(Sel_SC),
    .controleOperacao(controleOperacao), .Hab_Escrita(Hab_Escrita),
    .Hab_Flags(Hab_Flags), .clear_Flags(clear_Flags), .out_valid(out_valid),
    .out_result(out_result), .out_flags(out_flags), .busy(busy)
  );

  int checks = 0, passes = 0, fails = 0;
  int mregs [4];
  logic [3:0] mflags;
  logic [15:0] last_res;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: plain integer arithmetic on 16-bit words
  function automatic void model(input int op, input int a, input int b,
                                output int res, output logic [3:0] f);
    int sa, sb, t;
    longint p;
    logic c, v;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    c = 1'b0; v = 1'b0; res = 0;
    case (op)
      0:  res = a;
      1:  begin t = a + b; res = t % 65536; c = (t >= 65536);
                v = (sa + sb > 32767) || (sa + sb < -32768); end
      2:  begin res = (a - b + 65536) % 65536; c = (a < b);
                v = (sa - sb > 32767) || (sa - sb < -32768); end
      3:  res = a & b;
      4:  res = a | b;
      5:  res = a ^ b;
      6:  res = 65535 - a;
      7:  begin res = (a + 1) % 65536; c = (a == 65535); v = (a == 32767); end
      8:  begin res = (a + 65535) % 65536; c = (a == 0); v = (a == 32768); end
      9:  begin res = (a * 2) % 65536; c = (a >= 32768); end
      10: begin res = a / 2; c = ((a % 2) == 1); end
      11: begin res = ((sa >>> 1) + 65536) % 65536; c = ((a % 2) == 1); end
      12: begin p = longint'(a) * longint'(b); res = int'(p % 65536); c = (p >= 65536); end
      default: res = 0;
    endcase
    f = {(res == 0), (res >= 32768), c, v};
  endfunction

  // one op; returns once its WB result is visible (MUL waits out the iteration)
  task automatic issue(input int op, input int sa, input int sb, input int sc,
                       input bit we, input bit fe, input bit clr);
    int res;
    logic [3:0] f;
    logic [31:0] opv, sav, sbv, scv;
    @(negedge clk);
    chk("issue_ready", in_ready, 1);
    opv = op; sav = sa; sbv = sb; scv = sc;
    in_valid = 1'b1; controleOperacao = opv[4:0];
    Sel_SA = sav[1:0]; Sel_SB = sbv[1:0]; Sel_SC = scv[1:0];
    Hab_Escrita = we; Hab_Flags = fe;
    model(op, mregs[sa], mregs[sb], res, f);
    if (we && op <= 12) mregs[sc] = res;
    if (clr) mflags = 4'b0000;
    else if (fe && op <= 12) mflags = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (op == 12) begin
      clear_Flags = 1'b0;
      for (int i = 0; i < 16; i++) begin
        chk("mul_busy", busy, 1);
        chk("mul_not_ready", in_ready, 0);
        chk("mul_no_out", out_valid, 0);
        // junk request while busy must be ignored
        in_valid = (i < 15); controleOperacao = 5'h07;
        Sel_SA = 2'd0; Sel_SC = 2'd0; Hab_Escrita = 1'b1; Hab_Flags = 1'b1;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("mul_done_busy", busy, 0);
    end else begin
      clear_Flags = clr;
    end
    chk("wb_valid", out_valid, 1);
    chk("wb_result", out_result, res);
    last_res = out_result;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    chk("idle_no_out", out_valid, 0);
    chk("idle_result0", out_result, 0);
    chk("idle_flags", out_flags, mflags);
    clear_Flags = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    foreach (mregs[i]) mregs[i] = 0;
    mflags = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_result", out_result, 0);
    reset_n = 1'b1;

    // PASS_A R0 -> 0, Z
    issue(0, 0, 0, 0, 0, 1, 0);
    chk("pass0_res", last_res, 16'h0000);
    idle();
    chk("pass0_flags", out_flags, 4'b1000);

    // R2=0001, R1=FFFF->7FFF (forwarded), ADD -> 8000 N,V
    issue(7, 0, 0, 2, 1, 0, 0);
    issue(8, 0, 0, 1, 1, 0, 0);
    issue(10, 1, 0, 1, 1, 0, 0);
    issue(1, 1, 2, 3, 1, 1, 0);
    chk("add_res", last_res, 16'h8000);
    idle();
    chk("add_flags", out_flags, 4'b0101);

    // back-to-back forwarding: R3=8001, R0=R3+R3=0002 C,V
    issue(7, 3, 0, 3, 1, 1, 0);
    issue(1, 3, 3, 0, 1, 1, 0);
    chk("fwd_res", last_res, 16'h0002);
    idle();
    chk("fwd_flags", out_flags, 4'b0011);

    // SUB 0001-7FFF, then same with clear on the WB edge
    issue(2, 2, 1, 3, 0, 1, 0);
    chk("sub_res", last_res, 16'h8002);
    idle();
    chk("sub_flags", out_flags, 4'b0110);
    issue(2, 2, 1, 3, 0, 1, 1);
    idle();
    chk("clr_wins", out_flags, 4'b0000);

    // build R1=00FF, R2=0101
    issue(5, 1, 1, 1, 1, 0, 0);
    issue(8, 1, 0, 1, 1, 0, 0);
    repeat (8) issue(10, 1, 0, 1, 1, 0, 0);
    issue(7, 1, 0, 2, 1, 0, 0);
    issue(7, 2, 0, 2, 1, 0, 0);
    issue(12, 1, 2, 3, 1, 1, 0);
    chk("mul1_res", last_res, 16'hFFFF);
    idle();
    chk("mul1_flags", out_flags, 4'b0100);
    issue(12, 3, 0, 3, 1, 1, 0);
    chk("mul2_res", last_res, 16'hFFFE);
    idle();
    chk("mul2_flags", out_flags, 4'b0110);

    // randomized mix
    repeat (60) begin
      op = $urandom_range(0, 15);
      if (op == 12 && $urandom_range(0, 3) != 0) op = 1;
      issue(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
    for (int r = 0; r < 4; r++) issue(0, r, 0, 0, 0, 0, 0);
    idle();

    // reset in the middle of a MUL
    issue(2, 0, 0, 0, 1, 1, 0);
    issue(8, 0, 0, 1, 1, 0, 0);
    idle();
    chk("pre_rst_flags", out_flags, 4'b1000);
    @(negedge clk);
    in_valid = 1'b1; controleOperacao = 5'h0C;
    Sel_SA = 2'd1; Sel_SB = 2'd1; Sel_SC = 2'd2; Hab_Escrita = 1'b1; Hab_Flags = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort_busy_before", busy, 1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_flags", out_flags, 0);
    chk("abort_ready", in_ready, 1);
    foreach (mregs[i]) mregs[i] = 0;
    mflags = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_out", out_valid, 0);
    chk("post_rst_flags", out_flags, 0);
    for (int r = 0; r < 4; r++) issue(0, r, 0, 0, 0, 0, 0);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
